// File: rtl/rx_da_filter.sv
// -----------------------------------------------------------------------------
// rx_da_filter
//
// Destination-address filter for the MAC receive path. Assembles the 48-bit DA
// MSB-first from DATA_WIDTH-bit symbols (4 = MII, 8 = GMII) and classifies it
// as unicast, multicast or broadcast. The frame is then accepted or rejected
// against the promiscuous / broadcast / multicast mode bits and a
// runtime-programmable table of unicast addresses, scanned one entry per clock.
// The decision is a one-cycle ok/err pulse for the rx control FSM.
//
// Ports
//   clk, rst      clock, asynchronous active-low reset
//   I_en_ck       high while DA symbols are presented (one per cycle)
//   I_da          DA symbol
//   I_en_mix      promiscuous mode: accept everything
//   I_en_bc       accept broadcast
//   I_en_mc       accept any multicast
//   I_cfg_we      table write strobe
//   I_cfg_idx     table entry to write
//   I_cfg_addr    address to write
//   I_cfg_vld     valid bit written with the entry
//   O_da_ok       one-cycle accept pulse
//   O_da_err      one-cycle reject pulse
//   O_da_type     0 unicast, 1 multicast, 2 broadcast, 3 short DA
//   O_hit_idx     matching table entry on a table hit, else 0
//   O_busy        high while collecting or scanning
// -----------------------------------------------------------------------------
module rx_da_filter #(
  parameter int          DATA_WIDTH   = 4,
  parameter int          ADDR_ENTRIES = 4,
  parameter int          IDX_W        = 2,
  parameter logic [47:0] MAC_ADDR0    = 48'h000C294A3550
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  I_en_ck,
  input  logic [DATA_WIDTH-1:0] I_da,
  input  logic                  I_en_mix,
  input  logic                  I_en_bc,
  input  logic                  I_en_mc,
  input  logic                  I_cfg_we,
  input  logic [IDX_W-1:0]      I_cfg_idx,
  input  logic [47:0]           I_cfg_addr,
  input  logic                  I_cfg_vld,
  output logic                  O_da_ok,
  output logic                  O_da_err,
  output logic [1:0]            O_da_type,
  output logic [IDX_W-1:0]      O_hit_idx,
  output logic                  O_busy
);

  localparam int SYMS  = 48 / DATA_WIDTH;
  localparam int CNT_W = $clog2(SYMS + 1);

  localparam logic [1:0] TYPE_UC    = 2'd0;
  localparam logic [1:0] TYPE_MC    = 2'd1;
  localparam logic [1:0] TYPE_BC    = 2'd2;
  localparam logic [1:0] TYPE_SHORT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_SCAN    = 2'd2
  } state_t;

  state_t           state;
  logic [47:0]      da_sr;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] k;

  logic [47:0]             tbl_addr [ADDR_ENTRIES];
  logic [ADDR_ENTRIES-1:0] tbl_vld;

  // ---------------------------------------------------------------------------
  // Address table. Writes land at the next edge; a scan comparison on the same
  // edge still sees the old contents.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the table is reset explicitly (entry 0 holds the station address
      // out of reset), so it is built from flops rather than a RAM macro.
      for (int i = 0; i < ADDR_ENTRIES; i++) begin
        tbl_addr[i] <= (i == 0) ? MAC_ADDR0 : 48'h0;
      end
      tbl_vld <= ADDR_ENTRIES'(1);
    end else if (I_cfg_we) begin
      tbl_addr[I_cfg_idx] <= I_cfg_addr;
      tbl_vld[I_cfg_idx]  <= I_cfg_vld;
    end
  end

  // ---------------------------------------------------------------------------
  // DA decode, used while scanning.
  // ---------------------------------------------------------------------------
  logic        da_bcast;
  logic        da_mcast;
  logic [1:0]  da_type;
  logic        mode_hit;
  logic        entry_hit;
  logic        last_k;
  logic [47:0] da_shift;
  logic [47:0] da_first;

  // NOTE: every signal written in this always_comb is assigned on all paths,
  // so no latch can be inferred.
  always_comb begin
    da_bcast  = &da_sr;
    da_mcast  = da_sr[40];                  // I/G bit of the first octet
    da_type   = da_bcast ? TYPE_BC : (da_mcast ? TYPE_MC : TYPE_UC);
    mode_hit  = I_en_mix | (da_bcast & I_en_bc) | (da_mcast & I_en_mc);
    entry_hit = tbl_vld[k] && (tbl_addr[k] == da_sr);
    last_k    = (k == IDX_W'(ADDR_ENTRIES - 1));
    da_shift  = {da_sr[47-DATA_WIDTH:0], I_da};
    da_first  = {{(48-DATA_WIDTH){1'b0}}, I_da};
  end

  // ---------------------------------------------------------------------------
  // Collect / scan FSM with registered pulses.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every read
  // in this block sees the value from before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      da_sr     <= 48'h0;
      cnt       <= '0;
      k         <= '0;
      O_da_ok   <= 1'b0;
      O_da_err  <= 1'b0;
      O_da_type <= TYPE_UC;
      O_hit_idx <= '0;
    end else begin
      O_da_ok  <= 1'b0;
      O_da_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (I_en_ck) begin
            da_sr <= da_first;
            cnt   <= CNT_W'(1);
            state <= ST_COLLECT;
          end
        end

        ST_COLLECT: begin
          if (I_en_ck) begin
            // Symbols beyond a full DA are dropped; the counter saturates.
            if (cnt < CNT_W'(SYMS)) begin
              da_sr <= da_shift;
              cnt   <= cnt + CNT_W'(1);
            end
          end else if (cnt == CNT_W'(SYMS)) begin
            k     <= '0;
            state <= ST_SCAN;
          end else begin
            O_da_err  <= 1'b1;
            O_da_type <= TYPE_SHORT;
            O_hit_idx <= '0;
            state     <= ST_IDLE;
          end
        end

        ST_SCAN: begin
          if (I_en_ck) begin
            // A new frame started before the decision: drop this one silently
            // and treat the symbol as the first of the next DA.
            da_sr <= da_first;
            cnt   <= CNT_W'(1);
            state <= ST_COLLECT;
          end else if ((k == '0) && mode_hit) begin
            O_da_ok   <= 1'b1;
            O_da_type <= da_type;
            O_hit_idx <= '0;
            state     <= ST_IDLE;
          end else if (entry_hit) begin
            O_da_ok   <= 1'b1;
            O_da_type <= da_type;
            O_hit_idx <= k;
            state     <= ST_IDLE;
          end else if (last_k) begin
            O_da_err  <= 1'b1;
            O_da_type <= da_type;
            O_hit_idx <= '0;
            state     <= ST_IDLE;
          end else begin
            k <= k + IDX_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign O_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_rx_da_filter.sv
// -----------------------------------------------------------------------------
// tb_rx_da_filter
//
// Two instances (MII 4-bit and GMII 8-bit symbols) share reset, mode and table
// configuration. A bench-side model predicts, for every frame, the decision,
// type, hit index and the cycle of the pulse; one compare process checks both
// instances on every falling edge (pulse cycles and quiet cycles alike).
// Directed tests additionally pin selected results to hand-computed values.
// -----------------------------------------------------------------------------
module tb_rx_da_filter;

  localparam logic [47:0] MAC0  = 48'h000C294A3550;
  localparam logic [47:0] ENT2  = 48'h020000000001;
  localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] MCAST = 48'h01005E000001;
  localparam logic [47:0] OTHER = 48'h123456789ABC;
  localparam int          N     = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  en_ck_v;
  logic [3:0]  da4;
  logic [7:0]  da8;
  logic        en_mix, en_bc, en_mc;
  logic        cfg_we, cfg_vld;
  logic [1:0]  cfg_idx;
  logic [47:0] cfg_addr;
  logic [1:0]  ok_v, err_v, busy_v;
  logic [1:0]  typ4, typ8, hit4, hit8;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rx_da_filter #(.DATA_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .I_en_ck(en_ck_v[0]), .I_da(da4),
    .I_en_mix(en_mix), .I_en_bc(en_bc), .I_en_mc(en_mc),
    .I_cfg_we(cfg_we), .I_cfg_idx(cfg_idx), .I_cfg_addr(cfg_addr), .I_cfg_vld(cfg_vld),
    .O_da_ok(ok_v[0]), .O_da_err(err_v[0]), .O_da_type(typ4), .O_hit_idx(hit4),
    .O_busy(busy_v[0])
  );

  rx_da_filter #(.DATA_WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .I_en_ck(en_ck_v[1]), .I_da(da8),
    .I_en_mix(en_mix), .I_en_bc(en_bc), .I_en_mc(en_mc),
    .I_cfg_we(cfg_we), .I_cfg_idx(cfg_idx), .I_cfg_addr(cfg_addr), .I_cfg_vld(cfg_vld),
    .O_da_ok(ok_v[1]), .O_da_err(err_v[1]), .O_da_type(typ8), .O_hit_idx(hit8),
    .O_busy(busy_v[1])
  );

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: address table, expected-pulse queues, held type/index.
  // ---------------------------------------------------------------------------
  typedef struct {
    int         cyc;
    bit         ok;
    logic [1:0] typ;
    logic [1:0] idx;
  } exp_t;

  logic [47:0] m_addr [N];
  bit          m_vld  [N];
  exp_t        q4[$];
  exp_t        q8[$];
  logic [1:0]  last_typ [2];
  logic [1:0]  last_idx [2];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_addr[i] = (i == 0) ? MAC0 : 48'h0;
      m_vld[i]  = (i == 0);
    end
  endtask

  // Decision and latency (cycles after the first idle edge) for one frame.
  function automatic void classify(input logic [47:0] da, input int nsym, input int syms,
                                   output exp_t e, output int lat);
    e.cyc = 0;
    e.idx = 2'd0;
    if (nsym < syms) begin
      e.ok  = 1'b0;
      e.typ = 2'd3;
      lat   = 0;
      return;
    end
    e.typ = (da == BCAST) ? 2'd2 : (da[40] ? 2'd1 : 2'd0);
    if (en_mix || (da == BCAST && en_bc) || (da[40] && en_mc)) begin
      e.ok = 1'b1;
      lat  = 1;
      return;
    end
    e.ok = 1'b0;
    lat  = N;
    for (int i = 0; i < N; i++) begin
      if (m_vld[i] && m_addr[i] == da) begin
        e.ok  = 1'b1;
        e.idx = 2'(i);
        lat   = 1 + i;
        break;
      end
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Compare process.
  // ---------------------------------------------------------------------------
  task automatic cmp_one(input int d, input logic ok, input logic err,
                         input logic [1:0] typ, input logic [1:0] idx);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (!rst) begin
      check($sformatf("dut%0d_rst_out", d), {ok, err, typ, idx, busy_v[d]}, 48'h0);
      if (d == 0) q4.delete(); else q8.delete();
      last_typ[d] = 2'd0;
      last_idx[d] = 2'd0;
      return;
    end
    if (d == 0 && q4.size() > 0) begin e = q4[0]; have = 1'b1; end
    if (d == 1 && q8.size() > 0) begin e = q8[0]; have = 1'b1; end
    if (have && e.cyc < cyc) begin
      check($sformatf("dut%0d_pulse_missed", d), 48'(cyc), 48'(e.cyc));
      if (d == 0) void'(q4.pop_front()); else void'(q8.pop_front());
      have = 1'b0;
    end
    if (have && e.cyc == cyc) begin
      check($sformatf("dut%0d_ok", d),   ok,  e.ok);
      check($sformatf("dut%0d_err", d),  err, !e.ok);
      check($sformatf("dut%0d_type", d), typ, e.typ);
      check($sformatf("dut%0d_idx", d),  idx, e.idx);
      last_typ[d] = e.typ;
      last_idx[d] = e.idx;
      if (d == 0) void'(q4.pop_front()); else void'(q8.pop_front());
    end else begin
      check($sformatf("dut%0d_quiet", d), {ok, err}, 2'b00);
      check($sformatf("dut%0d_hold", d),  {typ, idx}, {last_typ[d], last_idx[d]});
    end
  endtask

  always @(negedge clk) begin
    cmp_one(0, ok_v[0], err_v[0], typ4, hit4);
    cmp_one(1, ok_v[1], err_v[1], typ8, hit8);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers.
  // ---------------------------------------------------------------------------
  task automatic drive_syms(input bit w8, input logic [47:0] da, input int nsym);
    logic [47:0] s;
    int dw;
    int syms;
    dw   = w8 ? 8 : 4;
    syms = 48 / dw;
    for (int i = 0; i < nsym; i++) begin
      @(posedge clk);
      #1;
      if (i < syms) s = da >> (48 - (i + 1) * dw);
      else          s = '1;
      en_ck_v[w8] = 1'b1;
      if (w8) da8 = s[7:0];
      else    da4 = s[3:0];
    end
  endtask

  // Drops I_en_ck after the last symbol; returns the first idle edge (E1).
  task automatic finish_da(input bit w8, input logic [47:0] da, input int nsym, output int e1);
    exp_t e;
    int   lat;
    @(posedge clk);
    #1;
    en_ck_v[w8] = 1'b0;
    e1 = cyc + 1;
    classify(da, nsym, w8 ? 6 : 12, e, lat);
    e.cyc = e1 + lat;
    if (w8) q8.push_back(e); else q4.push_back(e);
  endtask

  task automatic send_da(input bit w8, input logic [47:0] da, input int nsym, output int e1);
    drive_syms(w8, da, nsym);
    finish_da(w8, da, nsym, e1);
  endtask

  // Hand-computed expectation at a specific cycle.
  task automatic expect_at(input string name, input bit w8, input int target,
                           input bit ok, input logic [1:0] typ, input logic [1:0] idx);
    do @(negedge clk); while (cyc < target);
    check(name, {ok_v[w8], err_v[w8], (w8 ? typ8 : typ4), (w8 ? hit8 : hit4)},
                {ok, !ok, typ, idx});
  endtask

  task automatic write_entry(input logic [1:0] idx, input logic [47:0] addr, input bit vld);
    @(posedge clk);
    #1;
    cfg_we = 1'b1; cfg_idx = idx; cfg_addr = addr; cfg_vld = vld;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    m_addr[idx] = addr;
    m_vld[idx]  = vld;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic set_modes(input bit mix, input bit bc, input bit mc);
    en_mix = mix; en_bc = bc; en_mc = mc;
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog.
  // ---------------------------------------------------------------------------
  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish within 20000 cycles");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed sequence.
  // ---------------------------------------------------------------------------
  initial begin
    int e1;
    en_ck_v = 2'b00; da4 = '0; da8 = '0;
    set_modes(0, 0, 0);
    cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_vld = 1'b0;
    last_typ[0] = 2'd0; last_typ[1] = 2'd0;
    last_idx[0] = 2'd0; last_idx[1] = 2'd0;
    model_reset();

    idle(3);
    @(negedge clk);
    check("reset_outputs", {ok_v, err_v, busy_v, typ4, hit4, typ8, hit8}, 48'h0);
    #1 rst = 1'b1;
    idle(2);

    // Unicast hit on entry 0, MII.
    send_da(0, MAC0, 12, e1);
    expect_at("uc_hit_e0", 0, e1 + 1, 1, 2'd0, 2'd0);
    idle(2);

    // Table scan hit at entry 2, then invalidated entry -> miss.
    write_entry(2, ENT2, 1);
    send_da(0, ENT2, 12, e1);
    expect_at("tbl_hit_e2", 0, e1 + 3, 1, 2'd0, 2'd2);
    idle(2);
    write_entry(2, ENT2, 0);
    send_da(0, ENT2, 12, e1);
    expect_at("tbl_miss", 0, e1 + 4, 0, 2'd0, 2'd0);
    idle(2);

    // Broadcast with and without the mode bit.
    set_modes(0, 1, 0);
    send_da(0, BCAST, 12, e1);
    expect_at("bc_accept", 0, e1 + 1, 1, 2'd2, 2'd0);
    idle(2);
    set_modes(0, 0, 0);
    send_da(0, BCAST, 12, e1);
    expect_at("bc_reject", 0, e1 + 4, 0, 2'd2, 2'd0);
    idle(2);

    // Multicast accept, then promiscuous with an unknown unicast DA.
    set_modes(0, 0, 1);
    send_da(0, MCAST, 12, e1);
    expect_at("mc_accept", 0, e1 + 1, 1, 2'd1, 2'd0);
    idle(2);
    set_modes(1, 0, 0);
    send_da(0, OTHER, 12, e1);
    expect_at("mix_accept", 0, e1 + 1, 1, 2'd0, 2'd0);
    idle(2);
    set_modes(0, 0, 0);

    // Multicast DA with its mode bit off falls through to the table.
    send_da(0, MCAST, 12, e1);
    idle(N + 3);

    // Short DA: 7 symbols.
    send_da(0, MAC0, 7, e1);
    expect_at("short_da", 0, e1, 0, 2'd3, 2'd0);
    idle(2);

    // 14 symbols: trailing all-ones symbols are ignored.
    send_da(0, MAC0, 14, e1);
    expect_at("long_da", 0, e1 + 1, 1, 2'd0, 2'd0);
    idle(2);

    // Abort: unknown DA scanning, I_en_ck reasserted at the k=1 edge.
    drive_syms(0, OTHER, 12);
    @(posedge clk); #1 en_ck_v[0] = 1'b0;
    @(posedge clk); #1;
    check("busy_scan", busy_v[0], 1'b1);
    send_da(0, MAC0, 12, e1);
    expect_at("after_abort", 0, e1 + 1, 1, 2'd0, 2'd0);
    idle(N + 3);

    // Reset mid-COLLECT restores entry 0.
    write_entry(0, 48'h000000000010, 1);
    drive_syms(0, MAC0, 5);
    @(negedge clk);
    check("busy_collect", busy_v[0], 1'b1);
    #2;
    rst = 1'b0;
    en_ck_v = 2'b00;
    model_reset();
    @(negedge clk);
    check("rst_mid_collect", {ok_v[0], err_v[0], typ4, hit4, busy_v[0]}, 48'h0);
    @(posedge clk); #1 rst = 1'b1;
    idle(2);
    send_da(0, MAC0, 12, e1);
    expect_at("post_rst_hit", 0, e1 + 1, 1, 2'd0, 2'd0);
    idle(2);

    // GMII instance: hit, table hit, miss.
    send_da(1, MAC0, 6, e1);
    expect_at("gmii_hit_e0", 1, e1 + 1, 1, 2'd0, 2'd0);
    idle(2);
    write_entry(2, ENT2, 1);
    send_da(1, ENT2, 6, e1);
    expect_at("gmii_hit_e2", 1, e1 + 3, 1, 2'd0, 2'd2);
    idle(2);
    write_entry(2, ENT2, 0);
    send_da(1, ENT2, 6, e1);
    expect_at("gmii_miss", 1, e1 + 4, 0, 2'd0, 2'd0);
    idle(2);
    send_da(1, MAC0, 3, e1);
    expect_at("gmii_short", 1, e1, 0, 2'd3, 2'd0);
    idle(N + 3);

    check("q4_drained", 48'(q4.size()), 48'h0);
    check("q8_drained", 48'(q8.size()), 48'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
